// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, grant index and
// a hold limit that forcibly ends an ownership after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {found, index} of the first set request searching from p upward (mod 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t           state_r, state_s;
  logic [7:0]       grant_r, grant_s;
  logic [2:0]       grant_id_r, grant_id_s;
  logic             grant_valid_r, grant_valid_s;
  logic             timeout_r, timeout_s;
  logic [2:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [3:0]       pick_s;
  logic             lim_s;
  logic             release_s;

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    grant_id_s    = grant_id_r;
    grant_valid_s = grant_valid_r;
    timeout_s     = 1'b0;
    ptr_s         = ptr_r;
    hold_cnt_s    = hold_cnt_r;
    pick_s        = rr_pick(req, ptr_r);
    lim_s         = HOLD_EN && (hold_cnt_r == HOLD_LAST);
    release_s     = done | ~req[grant_id_r] | lim_s;

    case (state_r)
      ST_IDLE: begin
        if (pick_s[3]) begin
          grant_s       = 8'b0000_0001 << pick_s[2:0];
          grant_id_s    = pick_s[2:0];
          grant_valid_s = 1'b1;
          hold_cnt_s    = {CNT_W{1'b0}};
          state_s       = ST_GRANT;
        end else begin
          grant_s       = 8'b0000_0000;
          grant_valid_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          grant_s       = 8'b0000_0000;
          grant_valid_s = 1'b0;
          ptr_s         = grant_id_r + 3'd1;
          // Only a genuine limit expiry pulses timeout; done or a dropped request win.
          timeout_s     = lim_s & ~done & req[grant_id_r];
          state_s       = ST_IDLE;
        end else if (hold_cnt_r != CNT_MAX) begin
          hold_cnt_s    = hold_cnt_r + CNT_ONE;
        end else begin
          hold_cnt_s    = hold_cnt_r;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        grant_s       = 8'b0000_0000;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      grant_r       <= 8'b0000_0000;
      grant_id_r    <= 3'd0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
      ptr_r         <= 3'd0;
      hold_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      grant_id_r    <= grant_id_s;
      grant_valid_r <= grant_valid_s;
      timeout_r     <= timeout_s;
      ptr_r         <= ptr_s;
      hold_cnt_r    <= hold_cnt_s;
    end
  end

  assign grant       = grant_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Table-driven bench for rr_arbiter8 (MAX_HOLD=4) with hand sequences for the
// hold limit and reset-while-granted cases.
module tb_rr_arbiter8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] e_grant;
    logic [2:0] e_id;
    logic       e_valid;
    logic       e_to;
  } vec_t;

  vec_t tbl[$];

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] q, input logic d,
                              input logic [7:0] g, input logic [2:0] id,
                              input logic v, input logic t);
    vec_t x;
    x.rst = r; x.req = q; x.done = d;
    x.e_grant = g; x.e_id = id; x.e_valid = v; x.e_to = t;
    return x;
  endfunction

  // Drive inputs for one cycle, then compare the registered outputs after the edge.
  task automatic step(input vec_t v, input string name);
    reset = v.rst;
    req   = v.req;
    done  = v.done;
    @(posedge clk);
    #1;
    total++;
    if (grant !== v.e_grant || grant_id !== v.e_id ||
        grant_valid !== v.e_valid || timeout !== v.e_to) begin
      bad++;
      $display("FAIL %s: got grant=%h id=%0d valid=%b timeout=%b, want grant=%h id=%0d valid=%b timeout=%b",
               name, grant, grant_id, grant_valid, timeout,
               v.e_grant, v.e_id, v.e_valid, v.e_to);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;

    // Reset held with all requests up, then first grant goes to 0.
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    // Single requester: three granted cycles, done on the third, re-win after idle.
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    // Fairness: done held high (ignored in IDLE), owners 0..7 then 0 again.
    tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0));
    end
    // Wrap search: owner 4 releases, then 8'h12 must pick bit 1.
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h10, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h12, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h12, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Hold limit: owner 0 keeps its grant exactly 4 cycles, then timeout pulses.
    step(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "hold_rst");
    for (int c = 0; c < 4; c++)
      step(mk(1'b0, 8'h09, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0), $sformatf("hold_cyc%0d", c));
    step(mk(1'b0, 8'h09, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1), "hold_timeout");
    step(mk(1'b0, 8'h09, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0), "hold_next_owner");
    step(mk(1'b0, 8'h01, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0), "hold_owner3_done");
    // Owner 0 drops its request on its 4th cycle: limit reached but no timeout.
    for (int c = 0; c < 4; c++)
      step(mk(1'b0, 8'h09, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0), $sformatf("drop_cyc%0d", c));
    step(mk(1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "drop_no_timeout");
    step(mk(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0), "drop_next_owner");
    // Done coinciding with the limit also suppresses timeout.
    for (int c = 0; c < 3; c++)
      step(mk(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0), $sformatf("done_lim_cyc%0d", c));
    step(mk(1'b0, 8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0), "done_lim_no_timeout");

    // Reset while owner 5 is granted: grant drops, no timeout, ptr back to 0.
    step(mk(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "midrst_pre");
    step(mk(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0), "midrst_grant");
    step(mk(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0), "midrst_hold");
    step(mk(1'b1, 8'h21, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0), "midrst_reset");
    step(mk(1'b0, 8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0), "midrst_regrant");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
